// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC owner, 1-cycle ROM driver, prefetch FIFO.
// Optional perf counters when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter int PC_WID      = 8,
  parameter int INSTR_WID   = 16,
  parameter int OFFSET_WID  = 6,
  parameter int FETCH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable1,
  input  logic                  branch_taken,
  input  logic [PC_WID-1:0]     branch_base,
  input  logic [OFFSET_WID-1:0] branch_offse,
  output logic                  imem_en,
  output logic [PC_WID-1:0]     imem_addr,
  input  logic [INSTR_WID-1:0]  imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WID-1:0]     out_pc,
  output logic [INSTR_WID-1:0]  out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int AW = $clog2(FETCH_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FETCH_DEPTH);

  logic [PC_WID-1:0]    fetch_pc_q, fetch_pc_d;
  logic                 inflight_q, inflight_d;
  logic [PC_WID-1:0]    inflight_pc_q, inflight_pc_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PC_WID-1:0]    pc_mem_q    [FETCH_DEPTH];
  logic [INSTR_WID-1:0] instr_mem_q [FETCH_DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CW-1:0]     occ;
  logic [PC_WID-1:0] target;

  // Handshake, credit and redirect-target decode.
  always_comb begin
    pop    = (count_q != '0) && out_ready;
    push   = inflight_q && !branch_taken;
    // Slots committed after this edge; a same-cycle pop frees one.
    occ    = count_q + CW'(inflight_q) - CW'(pop);
    issue  = !rst && enable1 && !branch_taken && (occ < DEPTH_C);
    target = branch_base + PC_WID'($signed(branch_offse));
  end

  // Next-state for PC, in-flight tracking and FIFO pointers.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    if (branch_taken) begin
      fetch_pc_d = target;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + PC_WID'(1);
        inflight_pc_d = fetch_pc_q;
      end
      wptr_d  = wptr_q + AW'(push);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; a returning word is written unless killed by redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wptr_q]    <= inflight_pc_q;
      instr_mem_q[wptr_q] <= imem_rdata;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rptr_q];
  assign out_instr = instr_mem_q[rptr_q];

`ifdef IF_PERF_CNT_EN
  // Saturating issue and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a random run
// checked against a queue-based model of the fetch stage.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable1 = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_base = '0;
  logic [5:0]  branch_offse = '0;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pc;
  logic [15:0] out_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .enable1      (enable1),
    .branch_taken (branch_taken),
    .branch_base  (branch_base),
    .branch_offse (branch_offse),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  function automatic logic [7:0] tgt_f(input logic [7:0] b, input logic [5:0] o);
    int off;
    off = (o >= 6'd32) ? int'(o) - 64 : int'(o);
    return 8'((int'(b) + off) & 255);
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom_f(imem_addr);
  end

  // Reference model: queue of delivered PCs plus one outstanding read.
  logic [7:0]  m_q[$];
  bit          m_infl = 1'b0;
  logic [7:0]  m_infl_pc = '0;
  logic [7:0]  m_pc = '0;
  int unsigned m_fetch = 0;
  int unsigned m_stall = 0;

  always @(posedge clk or posedge rst) begin : model
    bit mpop;
    bit miss;
    int used;
    if (rst) begin
      m_q.delete();
      m_infl    = 1'b0;
      m_infl_pc = '0;
      m_pc      = '0;
      m_fetch   = 0;
      m_stall   = 0;
    end else begin
      mpop = out_ready && (m_q.size() > 0);
      used = m_q.size() - (mpop ? 1 : 0) + (m_infl ? 1 : 0);
      miss = enable1 && !branch_taken && (used < DEPTH);
      if (m_q.size() > 0 && !out_ready) m_stall++;
      if (miss) m_fetch++;
      if (branch_taken) begin
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = tgt_f(branch_base, branch_offse);
      end else begin
        if (mpop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl = miss;
        if (miss) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 8'd1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    enable1 = 1'b0;
    branch_taken = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_en !== 1'b0 || imem_addr !== 8'h00)
      $display("FAIL reset_imem: en=%b addr=%h want en=0 addr=00", imem_en, imem_addr);
    else n_pass++;
    n_chk++;
    if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_instr !== 16'h0000)
      $display("FAIL reset_out: v=%b pc=%h ins=%h want 0/00/0000", out_valid, out_pc, out_instr);
    else n_pass++;
    enable1 = 1'b1;
    #1;
    n_chk++;
    if (imem_en !== 1'b0)
      $display("FAIL reset_gate_en: en=%b want 0", imem_en);
    else n_pass++;
    enable1 = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    enable1 = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if (imem_en !== 1'b1 || imem_addr !== 8'(c))
        $display("FAIL stream_issue c=%0d: en=%b addr=%h want 1/%h", c, imem_en, imem_addr, 8'(c));
      else n_pass++;
      n_chk++;
      if (c < 2) begin
        if (out_valid !== 1'b0)
          $display("FAIL stream_early c=%0d: v=%b want 0", c, out_valid);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b1 || out_pc !== 8'(c - 2) || out_instr !== rom_f(8'(c - 2)))
          $display("FAIL stream_out c=%0d: v=%b pc=%h ins=%h want 1/%h/%h",
                   c, out_valid, out_pc, out_instr, 8'(c - 2), rom_f(8'(c - 2)));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    int issued;
    do_reset();
    enable1 = 1'b1;
    out_ready = 1'b0;
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (imem_en) issued++;
    end
    n_chk++;
    if (issued != DEPTH || imem_en !== 1'b0)
      $display("FAIL stall_issue: issued=%0d en=%b want %0d/0", issued, imem_en, DEPTH);
    else n_pass++;
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00)
      $display("FAIL stall_hold: v=%b pc=%h want 1/00", out_valid, out_pc);
    else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 8'(k) || out_instr !== rom_f(8'(k)))
        $display("FAIL stall_release k=%0d: v=%b pc=%h want 1/%h", k, out_valid, out_pc, 8'(k));
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    enable1 = 1'b1;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    branch_taken = 1'b1;
    branch_base = 8'h10;
    branch_offse = 6'h3C;
    #1;
    n_chk++;
    if (imem_en !== 1'b0)
      $display("FAIL branch_no_issue: en=%b want 0", imem_en);
    else n_pass++;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_en !== 1'b1 || imem_addr !== 8'h0C || out_valid !== 1'b0)
      $display("FAIL branch_target: en=%b addr=%h v=%b want 1/0c/0", imem_en, imem_addr, out_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL branch_gap: v=%b want 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 8'h0C || out_instr !== rom_f(8'h0C))
      $display("FAIL branch_deliver: v=%b pc=%h want 1/0c", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    enable1 = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    branch_taken = 1'b1;
    branch_base = 8'hFE;
    branch_offse = 6'h05;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    @(negedge clk);
    n_chk++;
    if (imem_en !== 1'b1 || imem_addr !== 8'h03)
      $display("FAIL wrap_target: en=%b addr=%h want 1/03", imem_en, imem_addr);
    else n_pass++;
    branch_taken = 1'b1;
    branch_offse = 6'h01;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    @(negedge clk);
    n_chk++;
    if (imem_addr !== 8'hFF || imem_en !== 1'b1)
      $display("FAIL wrap_ff: en=%b addr=%h want 1/ff", imem_en, imem_addr);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (imem_addr !== 8'h00 || imem_en !== 1'b1)
      $display("FAIL wrap_00: en=%b addr=%h want 1/00", imem_en, imem_addr);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00)
      $display("FAIL wrap_deliver: v=%b pc=%h want 1/00", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_pop();
    int n;
    do_reset();
    enable1 = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 8'h02)
      $display("FAIL rpop_head: v=%b pc=%h want 1/02", out_valid, out_pc);
    else n_pass++;
    branch_taken = 1'b1;
    branch_base = 8'h40;
    branch_offse = 6'h00;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 2) begin
        n_chk++;
        if (out_valid !== 1'b0)
          $display("FAIL rpop_flushed k=%0d: v=%b pc=%h want 0", k, out_valid, out_pc);
        else n_pass++;
      end else if (out_valid) begin
        n_chk++;
        if (out_pc !== 8'(8'h40 + n))
          $display("FAIL rpop_seq k=%0d: pc=%h want %h", k, out_pc, 8'(8'h40 + n));
        else n_pass++;
        n++;
      end
    end
    n_chk++;
    if (n != 6)
      $display("FAIL rpop_count: got %0d deliveries want 6", n);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable1 = 1'b1;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1)
      $display("FAIL rmid_pre: v=%b want 1", out_valid);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || imem_en !== 1'b0)
      $display("FAIL rmid_async: v=%b en=%b want 0/0", out_valid, imem_en);
    else n_pass++;
`ifdef IF_PERF_CNT_EN
    n_chk++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL rmid_perf: f=%0d s=%0d want 0/0", perf_fetch_cnt, perf_stall_cnt);
    else n_pass++;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_en !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL rmid_refetch: en=%b addr=%h want 1/00", imem_en, imem_addr);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== rom_f(8'h00))
      $display("FAIL rmid_deliver: v=%b pc=%h want 1/00", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    int  errs;
    int  used;
    bit  e_valid;
    bit  e_en;
    do_reset();
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      enable1      = ($urandom_range(0, 7) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 15) == 0);
      branch_base  = 8'($urandom);
      branch_offse = 6'($urandom);
      @(negedge clk);
      e_valid = (m_q.size() > 0);
      used = m_q.size() - ((out_ready && e_valid) ? 1 : 0) + (m_infl ? 1 : 0);
      e_en = enable1 && !branch_taken && (used < DEPTH);
      n_chk++;
      if (imem_en !== e_en || (e_en && imem_addr !== m_pc)) begin
        $display("FAIL rand_issue c=%0d: en=%b addr=%h want %b/%h", c, imem_en, imem_addr, e_en, m_pc);
        errs++;
      end else n_pass++;
      n_chk++;
      if (out_valid !== e_valid ||
          (e_valid && (out_pc !== m_q[0] || out_instr !== rom_f(m_q[0])))) begin
        $display("FAIL rand_out c=%0d: v=%b pc=%h ins=%h want %b/%h", c, out_valid, out_pc,
                 out_instr, e_valid, e_valid ? m_q[0] : 8'h00);
        errs++;
      end else n_pass++;
      if (errs > 10) break;
      @(posedge clk);
      #1;
    end
    branch_taken = 1'b0;
`ifdef IF_PERF_CNT_EN
    n_chk++;
    if (perf_fetch_cnt !== m_fetch || perf_stall_cnt !== m_stall)
      $display("FAIL rand_perf: f=%0d s=%0d want %0d/%0d", perf_fetch_cnt, perf_stall_cnt, m_fetch, m_stall);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_redirect_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
